// File: rtl/nand_logic_pipe_if.sv
// Purpose: operand/result handshake bundle for nand_logic_pipe.
// Signals: in_valid/in_ready/a/b/op  - operand side (producer -> pipe)
//          out_valid/out_ready/out    - result side (pipe -> consumer)
//          txn_count                  - completed output transfers
// Modports: master = producer/consumer view, slave = pipeline view.
interface nand_logic_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [15:0]      txn_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, txn_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, txn_count
  );
endinterface

// File: rtl/nand_logic_pipe.sv
// Purpose: DEPTH-stage valid/ready pipeline computing a bitwise logic
//          operation (NAND by default) on WIDTH-bit operand pairs, with a
//          wrapping count of completed output transfers.
// Ports:   clk  - rising-edge clock
//          rst  - asynchronous active-high reset
//          bus  - nand_logic_pipe_if.slave (operands in, result out,
//                 in_ready is combinational through the ready chain)
module nand_logic_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  nand_logic_pipe_if.slave   bus
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_RNAND = 3'b111;

  logic [WIDTH-1:0] w_res;
  logic             w_rnand;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic             r_v [DEPTH];
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_rdy;
  logic [CNT_W-1:0] r_txn;
  logic             w_out_xfer;

  assign w_rnand = ~(&bus.a);

  // Operation decode at the pipeline input.
  always_comb begin
    w_res = '0;
    case (bus.op)
      OP_NAND:  w_res = ~(bus.a & bus.b);
      OP_AND:   w_res = bus.a & bus.b;
      OP_NOR:   w_res = ~(bus.a | bus.b);
      OP_OR:    w_res = bus.a | bus.b;
      OP_XOR:   w_res = bus.a ^ bus.b;
      OP_XNOR:  w_res = ~(bus.a ^ bus.b);
      OP_NOTA:  w_res = ~bus.a;
      OP_RNAND: w_res = WIDTH'(w_rnand);
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             w_src_v;
      logic [WIDTH-1:0] w_src_d;

      assign w_v[gi] = r_v[gi];
      // Stage can load unless it and every stage after it are full and the
      // consumer is stalling (closed form of the ripple ready chain).
      assign w_rdy[gi] = bus.out_ready | ~(&w_v[DEPTH-1:gi]);

      if (gi == 0) begin : g_src_in
        assign w_src_v = bus.in_valid;
        assign w_src_d = w_res;
      end else begin : g_src_prev
        assign w_src_v = r_v[gi-1];
        assign w_src_d = r_d[gi-1];
      end

      // Data only moves with a valid token so bubbles do not disturb it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v[gi] <= 1'b0;
          r_d[gi] <= '0;
        end else if (w_rdy[gi]) begin
          r_v[gi] <= w_src_v;
          if (w_src_v) begin
            r_d[gi] <= w_src_d;
          end
        end
      end
    end
  endgenerate

  assign w_out_xfer = r_v[DEPTH-1] & bus.out_ready;

  // Completed-transfer counter, wraps naturally at 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn <= '0;
    end else if (w_out_xfer) begin
      r_txn <= r_txn + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out       = r_d[DEPTH-1];
  assign bus.txn_count = r_txn;

endmodule

// File: tb/tb_nand_logic_pipe.sv
// Purpose: directed self-checking bench for nand_logic_pipe covering the
//          three parameter sets (8/2, 1/1, 64/4).
module tb_nand_logic_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nand_logic_pipe_if #(.WIDTH(8))  m_if ();
  nand_logic_pipe_if #(.WIDTH(1))  s_if ();
  nand_logic_pipe_if #(.WIDTH(64)) w_if ();

  nand_logic_pipe #(.WIDTH(8), .DEPTH(2)) u_dut_m (
    .clk (clk), .rst (rst), .bus (m_if.slave)
  );
  nand_logic_pipe #(.WIDTH(1), .DEPTH(1)) u_dut_s (
    .clk (clk), .rst (rst), .bus (s_if.slave)
  );
  nand_logic_pipe #(.WIDTH(64), .DEPTH(4)) u_dut_w (
    .clk (clk), .rst (rst), .bus (w_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sw_a  [9] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF};
  logic [2:0] sw_op [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
  logic [7:0] sw_e  [9] = '{8'hFA, 8'h05, 8'h50, 8'hAF, 8'hAA, 8'h55, 8'h5A, 8'h01, 8'h00};

  logic [7:0] bp_a  [5] = '{8'h01, 8'h0F, 8'h33, 8'h12, 8'h80};
  logic [7:0] bp_b  [5] = '{8'h03, 8'hF0, 8'h55, 8'h34, 8'h7F};
  logic [2:0] bp_op [5] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd2};
  logic [7:0] bp_e  [5] = '{8'h01, 8'hFF, 8'h66, 8'hED, 8'h00};

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         iidx;
    int         oidx;
    int         acc;
    int         n_in;
    int         n_out;
    int         stale;
    int         cyc;
    logic       take;
    logic [7:0] exp8;

    m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0; m_if.op = '0; m_if.out_ready = 1'b1;
    s_if.in_valid = 1'b0; s_if.a = '0; s_if.b = '0; s_if.op = '0; s_if.out_ready = 1'b1;
    w_if.in_valid = 1'b0; w_if.a = '0; w_if.b = '0; w_if.op = '0; w_if.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", m_if.out_valid, 0);
    check("rst_out", m_if.out, 0);
    check("rst_txn", m_if.txn_count, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", m_if.in_ready, 1);

    // Single NAND, latency DEPTH=2 edges
    m_if.a = 8'hF0; m_if.b = 8'hCC; m_if.op = 3'd0; m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    check("nand_lat1_valid", m_if.out_valid, 0);
    step();
    check("nand_valid", m_if.out_valid, 1);
    check("nand_out", m_if.out, 8'h3F);
    check("nand_txn_before", m_if.txn_count, 0);
    step();
    check("nand_txn", m_if.txn_count, 1);
    check("nand_drained", m_if.out_valid, 0);

    // Opcode sweep, back-to-back
    iidx = 0;
    oidx = 0;
    for (int c = 0; c < 30 && oidx < 9; c++) begin
      if (m_if.out_valid) begin
        check($sformatf("sweep[%0d]", oidx), m_if.out, sw_e[oidx]);
        oidx++;
      end
      if (iidx < 9) begin
        m_if.in_valid = 1'b1; m_if.a = sw_a[iidx]; m_if.b = 8'h0F; m_if.op = sw_op[iidx];
      end else begin
        m_if.in_valid = 1'b0;
      end
      #1;
      take = m_if.in_valid & m_if.in_ready;
      step();
      if (take) iidx++;
    end
    m_if.in_valid = 1'b0;
    check("sweep_count", oidx, 9);
    check("sweep_txn", m_if.txn_count, 10);

    // Backpressure: only DEPTH items fit
    m_if.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      m_if.in_valid = 1'b1; m_if.a = bp_a[acc]; m_if.b = bp_b[acc]; m_if.op = bp_op[acc];
      #1;
      take = m_if.in_ready;
      step();
      if (take) acc++;
    end
    m_if.a = bp_a[acc]; m_if.b = bp_b[acc]; m_if.op = bp_op[acc];
    #1;
    check("bp_accepted", acc, 2);
    check("bp_in_ready", m_if.in_ready, 0);
    check("bp_out_valid", m_if.out_valid, 1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_hold[%0d]", c), m_if.out, bp_e[0]);
      step();
    end
    m_if.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (acc < 5) begin
        m_if.in_valid = 1'b1; m_if.a = bp_a[acc]; m_if.b = bp_b[acc]; m_if.op = bp_op[acc];
      end else begin
        m_if.in_valid = 1'b0;
      end
      #1;
      check($sformatf("bp_drain_valid[%0d]", c), m_if.out_valid, 1);
      check($sformatf("bp_drain[%0d]", c), m_if.out, bp_e[c]);
      take = m_if.in_valid & m_if.in_ready;
      step();
      if (take) acc++;
    end
    m_if.in_valid = 1'b0;
    check("bp_all_in", acc, 5);
    check("bp_txn", m_if.txn_count, 15);

    // Simultaneous transfer with a full pipeline
    m_if.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_if.in_valid = 1'b1; m_if.a = 8'(k); m_if.b = 8'hFF; m_if.op = 3'd0;
      step();
    end
    m_if.a = 8'd2;
    #1;
    check("sim_full", m_if.in_ready, 0);
    m_if.out_ready = 1'b1;
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      m_if.a = 8'(c + 2);
      #1;
      check($sformatf("sim_rdy[%0d]", c), m_if.in_ready, 1);
      if (m_if.out_valid) begin
        exp8 = ~8'(c);
        check($sformatf("sim_out[%0d]", c), m_if.out, exp8);
        n_out++;
      end
      if (m_if.in_valid & m_if.in_ready) n_in++;
      step();
    end
    m_if.in_valid = 1'b0;
    check("sim_n_in", n_in, 10);
    check("sim_n_out", n_out, 10);

    // Reset mid-stream with two results in flight
    check("mid_inflight", m_if.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", m_if.out_valid, 0);
    check("mid_rst_out", m_if.out, 0);
    check("mid_rst_txn", m_if.txn_count, 0);
    step();
    step();
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      if (m_if.out_valid) stale++;
      step();
    end
    check("mid_no_stale", stale, 0);

    // Counter wrap
    m_if.in_valid = 1'b1; m_if.a = 8'h00; m_if.b = 8'h00; m_if.op = 3'd0;
    cyc = 0;
    while (m_if.txn_count != 16'hFFFF && cyc < 70000) begin
      step();
      cyc++;
    end
    check("wrap_reach", m_if.txn_count, 16'hFFFF);
    check("wrap_valid", m_if.out_valid, 1);
    step();
    check("wrap_zero", m_if.txn_count, 16'h0000);
    m_if.in_valid = 1'b0;
    repeat (3) step();

    // WIDTH=1, DEPTH=1: one-edge latency
    s_if.a = 1'b1; s_if.b = 1'b0; s_if.op = 3'd0; s_if.in_valid = 1'b1;
    #1;
    check("w1_in_ready", s_if.in_ready, 1);
    check("w1_pre_valid", s_if.out_valid, 0);
    step();
    s_if.in_valid = 1'b0;
    check("w1_valid", s_if.out_valid, 1);
    check("w1_out", s_if.out, 1);
    step();
    check("w1_drained", s_if.out_valid, 0);

    // WIDTH=64, DEPTH=4: four-edge latency
    w_if.a = 64'hF0F0_F0F0_F0F0_F0F0; w_if.b = 64'hCCCC_CCCC_CCCC_CCCC;
    w_if.op = 3'd0; w_if.in_valid = 1'b1;
    step();
    w_if.in_valid = 1'b0;
    for (int e = 1; e < 4; e++) begin
      check($sformatf("w64_lat%0d", e), w_if.out_valid, 0);
      step();
    end
    check("w64_valid", w_if.out_valid, 1);
    check("w64_out", w_if.out, 64'h3F3F_3F3F_3F3F_3F3F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
